// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- oversampling-free UART receiver (8N1, optional even parity).
//
// The raw line goes through a 2-FF synchronizer and a debouncer. The FSM
// then times bit centres with a counter that runs at the clock rate.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset (FSM/outputs only)
//   rx_i         raw asynchronous serial line, idle high
//   data_o[7:0]  last correctly received byte, held until the next good frame
//   valid_o      one-cycle pulse: data_o has just been updated
//   frame_err_o  one-cycle pulse: stop bit sampled low
//   busy_o       registered, high in every state except IDLE
//   parity_err_o one-cycle pulse on even-parity mismatch (macro build only)
//
// Build option: define UART_RX_PARITY_EN for 8E1 framing (adds the PARITY
// state and the parity_err_o port). Without it the block receives 8N1.
//
// uart_debouncer: its output takes a new level only once the last Latency
// synchronized samples all agree, so shorter pulses are ignored.

module uart_debouncer #(
  parameter int Latency = 4
) (
  input  logic clk_i,
  input  logic d_i,
  output logic q_o
);

  logic [Latency-1:0] win_reg;
  logic               q_reg;

  // No reset: the receiver FSM waits for a stable high line after reset.
  always_ff @(posedge clk_i) begin
    win_reg <= {win_reg[Latency-2:0], d_i};
    if (&win_reg) begin
      q_reg <= 1'b1;
    end else if (~|win_reg) begin
      q_reg <= 1'b0;
    end
  end

  assign q_o = q_reg;

endmodule

module uart_rx_ctrl #(
  parameter int ClkFreq    = 50000000,
  parameter int BaudRate   = 115200,
  parameter int DebLatency = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err_o
`endif
);

  localparam int Div  = ClkFreq / BaudRate;
  localparam int Half = Div / 2;
  localparam int CntW = $clog2(Div) + 1;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [1:0] sync_reg;
  logic       rxd;

  state_t            state_reg, state_next;
  logic [CntW-1:0]   cnt_reg, cnt_next;
  logic [2:0]        bit_reg, bit_next;
  logic [7:0]        shift_reg, shift_next;
  logic [7:0]        data_reg, data_next;
  logic              valid_reg, valid_next;
  logic              ferr_reg, ferr_next;
  logic              busy_reg, busy_next;
  logic              par_bad;
`ifdef UART_RX_PARITY_EN
  logic              par_bad_reg, par_bad_next;
  logic              perr_reg, perr_next;
`endif

  logic tick_half;
  logic tick_full;

  // Synchronizer is not reset; it only carries the line level.
  always_ff @(posedge clk_i) begin
    sync_reg <= {sync_reg[0], rx_i};
  end

  uart_debouncer #(
    .Latency(DebLatency)
  ) u_debouncer (
    .clk_i(clk_i),
    .d_i  (sync_reg[1]),
    .q_o  (rxd)
  );

  assign tick_half = (cnt_reg == CntW'(Half - 1));
  assign tick_full = (cnt_reg == CntW'(Div - 1));

`ifdef UART_RX_PARITY_EN
  assign par_bad = par_bad_reg;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= WAIT_HIGH;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      busy_reg  <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bad_reg <= 1'b0;
      perr_reg    <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
      busy_reg  <= busy_next;
`ifdef UART_RX_PARITY_EN
      par_bad_reg <= par_bad_next;
      perr_reg    <= perr_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next = par_bad_reg;
    perr_next    = 1'b0;
`endif

    case (state_reg)
      // After reset or a framing error the line may still be mid-frame;
      // only a high level proves we are between frames.
      WAIT_HIGH: begin
        if (rxd) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        cnt_next = '0;
        if (!rxd) begin
          state_next = START;
        end
      end
      // Re-check the start bit at its centre to reject short lows.
      START: begin
        if (tick_half) begin
          cnt_next = '0;
          bit_next = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_next = 1'b0;
`endif
          state_next = rxd ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + CntW'(1);
        end
      end
      DATA: begin
        if (tick_full) begin
          cnt_next   = '0;
          shift_next = {rxd, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          cnt_next = cnt_reg + CntW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_full) begin
          cnt_next     = '0;
          par_bad_next = (^shift_reg) ^ rxd;
          state_next   = STOP;
        end else begin
          cnt_next = cnt_reg + CntW'(1);
        end
      end
`endif
      STOP: begin
        if (tick_full) begin
          cnt_next = '0;
`ifdef UART_RX_PARITY_EN
          perr_next = par_bad_reg;
`endif
          if (rxd) begin
            if (!par_bad) begin
              data_next  = shift_reg;
              valid_next = 1'b1;
            end
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = WAIT_HIGH;
          end
        end else begin
          cnt_next = cnt_reg + CntW'(1);
        end
      end
      default: begin
        state_next = WAIT_HIGH;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign data_o      = data_reg;
  assign valid_o     = valid_reg;
  assign frame_err_o = ferr_reg;
  assign busy_o      = busy_reg;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_reg;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl at ClkFreq=1MHz, BaudRate=100k (DIV=10).
// Stimulus pushes the expected output event; a negedge monitor pops and
// compares whenever valid_o / frame_err_o / parity_err_o pulses.

module tb_uart_rx_ctrl;

  localparam int Div = 10;
`ifdef UART_RX_PARITY_EN
  localparam int FrameLen = 11 * Div;
`else
  localparam int FrameLen = 10 * Div;
`endif

  // Event kinds as {parity_err, frame_err, valid}
  localparam logic [2:0] EvValid = 3'b001;
  localparam logic [2:0] EvFerr  = 3'b010;
  localparam logic [2:0] EvPerr  = 3'b100;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       busy;
  logic       perr;
  logic       busy_seen;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   prev_v = -1;
  int   last_v = -1;
  int   gap;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_ctrl #(
    .ClkFreq   (1000000),
    .BaudRate  (100000),
    .DebLatency(4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .data_o      (data),
    .valid_o     (valid),
    .frame_err_o (ferr),
    .busy_o      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err_o(perr)
`endif
  );

`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endfunction

  // Monitor: one line per observed output event.
  exp_t e;
  always @(negedge clk) begin
    if (valid || ferr || perr) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got valid=%0b ferr=%0b perr=%0b data=0x%02h, required no pulse (t=%0t)",
                 valid, ferr, perr, data, $time);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", {29'd0, perr, ferr, valid}, {29'd0, e.kind});
        if (e.kind == EvValid) begin
          check("rx_data", {24'd0, data}, {24'd0, e.data});
        end
      end
      if (valid) begin
        prev_v = last_v;
        last_v = cyc;
      end
    end
  end

  task automatic expect_ev(logic [2:0] kind, logic [7:0] d);
    exp_t x;
    x.kind = kind;
    x.data = d;
    sb.push_back(x);
  endtask

  // All stimulus changes on the falling edge, away from DUT sampling.
  task automatic send_bit(logic b);
    rx = b;
    repeat (Div) @(negedge clk);
  endtask

  task automatic send_frame(logic [7:0] d, logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_bit);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(logic [7:0] d, logic par_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par_bit);
    send_bit(1'b1);
  endtask
`endif

  task automatic idle(int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Hold reset long enough for the synchronizer and debouncer to settle high.
    repeat (12) @(negedge clk);
    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_ferr", {31'd0, ferr}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("wait_high_to_idle", {31'd0, busy}, 32'd0);

    // Single good frame.
    expect_ev(EvValid, 8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("a5_data_held", {24'd0, data}, 32'hA5);
    check("a5_busy_low", {31'd0, busy}, 32'd0);

    // Back-to-back frames, no idle gap.
    expect_ev(EvValid, 8'h00);
    expect_ev(EvValid, 8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    check("b2b_data_held", {24'd0, data}, 32'hFF);
    gap = last_v - prev_v;
    $display("info b2b valid gap = %0d cycles", gap);
    check("b2b_gap_in_range", {31'd0, (gap >= FrameLen - 2) && (gap <= FrameLen + 2)}, 32'd1);

    // Stop bit low: framing error, line held low afterwards.
    expect_ev(EvFerr, 8'h00);
    send_frame(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_busy_held", {31'd0, busy}, 32'd1);
    check("ferr_data_kept", {24'd0, data}, 32'hFF);
    idle(30);
    check("ferr_busy_release", {31'd0, busy}, 32'd0);

    // 3-cycle glitch: filtered by the debouncer.
    rx = 1'b0;
    busy_seen = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20) begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
    end
    check("glitch3_no_busy", {31'd0, busy_seen}, 32'd0);

    // 5-cycle low: passes debouncer, rejected at start-bit centre.
    rx = 1'b0;
    busy_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
    end
    rx = 1'b1;
    repeat (20) begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
    end
    check("glitch5_busy_rise", {31'd0, busy_seen}, 32'd1);
    idle(20);
    check("glitch5_back_idle", {31'd0, busy}, 32'd0);

    // Reset during bit 3 of 0x81; remainder must not decode.
    fork
      send_frame(8'h81, 1'b1);
      begin
        repeat (4 * Div + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_data", {24'd0, data}, 32'h00);
        check("rst_mid_valid", {31'd0, valid}, 32'd0);
        check("rst_mid_ferr", {31'd0, ferr}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd1);
      end
    join
    idle(20);
    check("rst_mid_idle", {31'd0, busy}, 32'd0);
    check("rst_mid_data_after", {24'd0, data}, 32'h00);

    expect_ev(EvValid, 8'h42);
    send_frame(8'h42, 1'b1);
    idle(20);
    check("after_rst_data", {24'd0, data}, 32'h42);

`ifdef UART_RX_PARITY_EN
    expect_ev(EvValid, 8'h07);
    send_frame_par(8'h07, 1'b1);
    idle(20);
    expect_ev(EvPerr, 8'h00);
    send_frame_par(8'h07, 1'b0);
    idle(20);
    check("perr_data_kept", {24'd0, data}, 32'h07);
`endif

    repeat (20) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
